// File: rtl/hazard_ctrl_unit.sv
// Pipeline latch sequencer: turns cache hits, load-use, MEM-resolved redirects and halt
// into per-latch enable/flush strobes, with stall/flush counters and a dcache-wait watchdog.
module hazard_ctrl_unit #(
   parameter int unsigned DWAIT_MAX = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        exmem_dREN,
   input  logic        exmem_dWEN,
   input  logic        exmem_halt,
   input  logic        exmem_redirect,
   input  logic        idex_dREN,
   input  logic [4:0]  idex_rd,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        exmem_flush,
   output logic        exmem_dhit,
   output logic        memwb_en,
   output logic        memwb_flush,
   output logic        halted,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

   localparam logic [7:0] L_DWAIT_MAX = 8'(DWAIT_MAX);

   state_t      r_state;
   logic [7:0]  r_waitCnt;
   logic        r_halted;
   logic        r_memTimeout;
   logic [31:0] r_stallCycles;
   logic [15:0] r_flushCount;

   logic w_dstall;
   logic w_loadUse;
   logic w_istall;
   logic w_redirTaken;

   assign w_dstall  = (exmem_dREN | exmem_dWEN) & ~dhit;
   assign w_loadUse = idex_dREN && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
   assign w_istall  = ~ihit;

   assign exmem_dhit   = dhit;
   assign halted       = r_halted;
   assign mem_timeout  = r_memTimeout;
   assign stall_cycles = r_stallCycles;
   assign flush_count  = r_flushCount;

   // A redirect under a pending dcache miss loses to dstall, so the branch stays frozen
   // in EX/MEM and is taken on the release cycle.
   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_flush  = 1'b0;
      w_redirTaken = 1'b0;
      if (RST) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else begin
         unique case (r_state)
            DRAIN: begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
            end
            HALTED: begin
               pc_en    = 1'b0;
               ifid_en  = 1'b0;
               idex_en  = 1'b0;
               exmem_en = 1'b0;
               memwb_en = 1'b0;
            end
            RUN, DWAIT: begin
               if (exmem_halt) begin
                  pc_en       = 1'b0;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
               end else if (w_dstall) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_en     = 1'b0;
                  exmem_en    = 1'b0;
                  memwb_flush = 1'b1;
               end else if (exmem_redirect) begin
                  ifid_flush   = 1'b1;
                  idex_flush   = 1'b1;
                  exmem_flush  = 1'b1;
                  w_redirTaken = 1'b1;
               end else if (w_loadUse) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end else if (w_istall) begin
                  pc_en      = 1'b0;
                  ifid_flush = 1'b1;
               end
            end
         endcase
      end
   end

   // The watchdog only raises a sticky flag; recovery from a hung dcache is left to reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state       <= RUN;
         r_waitCnt     <= 8'd0;
         r_halted      <= 1'b0;
         r_memTimeout  <= 1'b0;
         r_stallCycles <= 32'd0;
         r_flushCount  <= 16'd0;
      end else begin
         unique case (r_state)
            RUN, DWAIT: begin
               if (!pc_en) r_stallCycles <= r_stallCycles + 32'd1;
               if (w_redirTaken) r_flushCount <= r_flushCount + 16'd1;
               if (r_state == DWAIT) begin
                  if (r_waitCnt == L_DWAIT_MAX) r_memTimeout <= 1'b1;
                  r_waitCnt <= r_waitCnt + 8'd1;
               end
               if (exmem_halt) begin
                  r_state <= DRAIN;
               end else if (w_dstall) begin
                  r_state <= DWAIT;
                  if (r_state == RUN) r_waitCnt <= 8'd0;
               end else begin
                  r_state <= RUN;
               end
            end
            DRAIN: begin
               r_state  <= HALTED;
               r_halted <= 1'b1;
            end
            HALTED: begin
               r_state <= HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios plus random traffic, expected
// latch actions come from a per-latch action table in the reference model.
module tb_hazard_ctrl_unit;

   localparam int TB_DWAIT_MAX = 3;

   // Per-latch actions: advance, hold, advance-as-bubble, reset-kill.
   localparam int ADV  = 0;
   localparam int HOLD = 1;
   localparam int BUB  = 2;
   localparam int KILL = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ihit = 1'b1, dhit = 1'b1;
   logic        exmem_dREN = 1'b0, exmem_dWEN = 1'b0, exmem_halt = 1'b0, exmem_redirect = 1'b0;
   logic        idex_dREN = 1'b0;
   logic [4:0]  idex_rd = 5'd0, ifid_rs1 = 5'd0, ifid_rs2 = 5'd0;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic        exmem_en, exmem_flush, exmem_dhit, memwb_en, memwb_flush;
   logic        halted, mem_timeout;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   hazard_ctrl_unit #(.DWAIT_MAX(TB_DWAIT_MAX)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt),
      .exmem_redirect(exmem_redirect), .idex_dREN(idex_dREN), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .exmem_flush(exmem_flush), .exmem_dhit(exmem_dhit),
      .memwb_en(memwb_en), .memwb_flush(memwb_flush),
      .halted(halted), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [9:0]  ctl;
      logic        hlt;
      logic        tmo;
      logic [31:0] stalls;
      logic [15:0] flushes;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: 0=running, 1=waiting on dcache, 2=draining halt, 3=halted.
   int          mMode = 0;
   int          mEpisode = 0;
   int          mHaltedFor = 0;
   logic        mHalted = 1'b0;
   logic        mTmo = 1'b0;
   logic [31:0] mStalls = 32'd0;
   logic [15:0] mFlushes = 16'd0;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a fresh set of strobes; pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("ctl", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                                    exmem_en, exmem_flush, memwb_en, memwb_flush, exmem_dhit}),
                        32'(e.ctl));
            checkOutput("halted", 32'(halted), 32'(e.hlt));
            checkOutput("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
            checkOutput("stall_cycles", stall_cycles, e.stalls);
            checkOutput("flush_count", 32'(flush_count), 32'(e.flushes));
         end
      end
   end

   task automatic applyStimulus(input logic rst, input logic ih, input logic dh,
                                input logic dr, input logic dw, input logic hl,
                                input logic rd_, input logic ld, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2);
      int   act[5];
      logic dMiss, loadUse, redirTaken;
      logic en[5];
      logic fl[5];
      exp_t e;
      @(negedge CLK);
      RST = rst; ihit = ih; dhit = dh; exmem_dREN = dr; exmem_dWEN = dw;
      exmem_halt = hl; exmem_redirect = rd_; idex_dREN = ld;
      idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;

      dMiss      = (dr || dw) && !dh;
      loadUse    = ld && (rd != 0) && (rd == rs1 || rd == rs2);
      redirTaken = 1'b0;
      act = '{ADV, ADV, ADV, ADV, ADV};
      if (rst)                 act = '{KILL, KILL, KILL, KILL, KILL};
      else if (mMode == 2)     act = '{HOLD, HOLD, HOLD, HOLD, BUB};
      else if (mMode == 3)     act = '{HOLD, HOLD, HOLD, HOLD, HOLD};
      else if (hl)             act = '{HOLD, BUB, BUB, BUB, ADV};
      else if (dMiss)          act = '{HOLD, HOLD, HOLD, HOLD, BUB};
      else if (rd_) begin      act = '{ADV, BUB, BUB, BUB, ADV}; redirTaken = 1'b1; end
      else if (loadUse)        act = '{HOLD, HOLD, BUB, ADV, ADV};
      else if (!ih)            act = '{HOLD, BUB, ADV, ADV, ADV};
      for (int i = 0; i < 5; i++) begin
         en[i] = (act[i] == ADV) || (act[i] == BUB);
         fl[i] = (act[i] == BUB) || (act[i] == KILL);
      end
      e.ctl     = {en[0], en[1], fl[1], en[2], fl[2], en[3], fl[3], en[4], fl[4], dh};
      e.hlt     = mHalted;
      e.tmo     = mTmo;
      e.stalls  = mStalls;
      e.flushes = mFlushes;
      expQ.push_back(e);

      if (rst) begin
         mMode = 0; mEpisode = 0; mHalted = 1'b0; mTmo = 1'b0;
         mStalls = 32'd0; mFlushes = 16'd0; mHaltedFor = 0;
      end else if (mMode == 2) begin
         mMode = 3; mHalted = 1'b1;
      end else if (mMode == 3) begin
         mHaltedFor++;
      end else begin
         if (!en[0]) mStalls = mStalls + 32'd1;
         if (redirTaken) mFlushes = mFlushes + 16'd1;
         if (mMode == 1) begin
            mEpisode++;
            if ((mEpisode % 256) == ((TB_DWAIT_MAX + 1) % 256)) mTmo = 1'b1;
         end
         if (hl) mMode = 2;
         else if (dMiss) begin
            if (mMode == 0) mEpisode = 0;
            mMode = 1;
         end else mMode = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
   endtask

   task automatic miss(input int n, input logic redir, input logic rst);
      for (int i = 0; i < n; i++)
         applyStimulus(rst, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, redir, 1'b0, 5'd0, 5'd1, 5'd2);
   endtask

   initial begin
      int wait_n;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      // Reset state and plain running.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(2);
      // Load-use on r5, then load-use together with an icache miss, then a pure icache miss.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
      idle(1);
      // Dcache miss for 4 cycles, then release.
      miss(4, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
      idle(1);
      // Redirect held behind a pending store miss, taken on the hit cycle.
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2);
      idle(1);
      // Watchdog trips during a long miss and stays set afterwards.
      miss(5, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
      idle(2);
      // Reset pulsed in the middle of a dcache wait.
      miss(3, 1'b0, 1'b0);
      miss(2, 1'b0, 1'b1);
      idle(2);
      // Halt: flush, drain, then absorbing halted state until reset.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
      for (int i = 0; i < 11; i++)
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(2);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic r;
         r = ($urandom_range(0, 99) < 1) || (mMode == 3 && mHaltedFor > 4);
         applyStimulus(r,
                       1'($urandom_range(0, 99) < 85),
                       1'($urandom_range(0, 99) < 55),
                       1'($urandom_range(0, 99) < 25),
                       1'($urandom_range(0, 99) < 10),
                       1'($urandom_range(0, 99) < 2),
                       1'($urandom_range(0, 99) < 12),
                       1'($urandom_range(0, 99) < 35),
                       5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)));
      end
      wait_n = 0;
      while (expQ.size() > 0 && wait_n < 10) begin
         @(negedge CLK);
         wait_n++;
      end
      #3;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain got=%0d want=0 pending expectations", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Per-core pipeline controller that sequences the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC register. It generates every latch `en`/`flush` from cache hits, load-use hazards, branch/jump redirects resolved in MEM, and `halt`. It also keeps stall/flush performance counters and a data-cache wait watchdog. One instance sits beside the datapath in each core.

## Interface
Parameters:
- `DWAIT_MAX`, 255: data-wait cycles before `mem_timeout` sets (8-bit compare).

Ports:
- `CLK` in 1: core clock, all state on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ihit` in 1: icache hit for current PC.
- `dhit` in 1: dcache hit for the EX/MEM access.
- `exmem_dREN`, `exmem_dWEN` in 1 each: memory access in EX/MEM (`dREN_o`, `dWEN_o`).
- `exmem_halt` in 1: halt in EX/MEM (`halt_o`).
- `exmem_redirect` in 1: taken branch or jump resolved in MEM.
- `idex_dREN` in 1: load in ID/EX.
- `idex_rd` in 5: load destination.
- `ifid_rs1`, `ifid_rs2` in 5: sources of the instruction in IF/ID.
- `pc_en` out 1: PC register enable.
- `ifid_en`, `ifid_flush` out 1 each.
- `idex_en`, `idex_flush` out 1 each.
- `exmem_en`, `exmem_flush`, `exmem_dhit` out 1 each. `exmem_dhit` is a copy of `dhit`.
- `memwb_en`, `memwb_flush` out 1 each.
- `halted` out 1: core halted, sticky until reset.
- `mem_timeout` out 1: sticky watchdog flag.
- `stall_cycles` out 32: cycles with `pc_en`=0 while in RUN or DWAIT. Wraps.
- `flush_count` out 16: redirect events. Wraps.

## Operation
- States: RUN, DWAIT, DRAIN, HALTED. Reset state is RUN.
- Condition terms, all combinational:
  - `dstall` = (`exmem_dREN` | `exmem_dWEN`) & ~`dhit`.
  - `lu` = `idex_dREN` & `idex_rd`≠0 & (`idex_rd`==`ifid_rs1` | `idex_rd`==`ifid_rs2`).
  - `istall` = ~`ihit`.
- Priority in RUN and DWAIT: `exmem_halt` > `dstall` > `exmem_redirect` > `lu` > `istall` > normal.
- Output sets. Any flag not listed is 0; any enable not listed is 1.
  - Normal: all enables 1.
  - `dstall`: `pc_en`, `ifid_en`, `idex_en`, `exmem_en` = 0; `memwb_flush`=1. The pipeline freezes and a bubble enters WB.
  - `exmem_redirect`: `pc_en`=1 (PC loads the target); `ifid_flush`, `idex_flush`, `exmem_flush` = 1. `flush_count`++.
  - `lu`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1. One bubble is inserted.
  - `istall`: `pc_en`=0, `ifid_flush`=1.
  - `exmem_halt` (RUN/DWAIT): `pc_en`=0; `ifid_flush`, `idex_flush`, `exmem_flush` = 1; `memwb_en`=1 so the halt advances to WB. Next state is DRAIN.
- Transitions:
  - RUN→DWAIT on `dstall`.
  - DWAIT→RUN on the first cycle with `dhit`=1. That cycle uses the normal/lower-priority output set.
  - DRAIN→HALTED unconditionally after 1 cycle.
  - HALTED is absorbing until `RST`.
- DRAIN outputs: all enables 0 except `memwb_en`=1. `memwb_flush`=1 to clear behind the retiring halt.
- HALTED outputs: all enables 0, flushes 0, `halted`=1. Counters freeze.
- Watchdog: 8-bit `wait_cnt` clears on entry to DWAIT and increments each DWAIT cycle. When `wait_cnt`==`DWAIT_MAX`, `mem_timeout` sets. The watchdog does not force a state change.
- `stall_cycles` increments in every RUN/DWAIT cycle where `pc_en`=0. This includes `dstall`, `lu`, `istall` and the halt cycle.

## Timing
- All outputs except `halted`, `mem_timeout` and the counters are combinational from state and inputs. They are valid within the same cycle for the latches to sample on the next edge.
- While `RST`=1:
  - all `*_en`=0 and all `*_flush`=1;
  - next state RUN;
  - `halted`=0, `mem_timeout`=0, `wait_cnt`=0;
  - `stall_cycles`=0, `flush_count`=0.
- Reset asserted mid-DWAIT or in HALTED returns to RUN on the next edge. No pending state survives.
- Load-use costs exactly 1 bubble. Redirect costs 3 flushed slots. Halt reaches `halted`=1 two edges after `exmem_halt` is first seen.
- `exmem_redirect` together with `dstall`: redirect is withheld until `dhit`. The branch stays frozen in EX/MEM and is taken on the release cycle.
- `lu` together with `istall`: the `lu` set applies. `ifid` is held, not flushed.
- Counter wrap: 32'hFFFFFFFF→0 and 16'hFFFF→0, with no flag.

## Test plan
- Load-use: load writes r5 in ID/EX, IF/ID reads r5, ihit=1 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1; `stall_cycles`=1.
- Dcache miss: `exmem_dREN`=1, `dhit` low for 4 cycles then high → DWAIT for 4 cycles with all upstream enables 0 and `memwb_flush`=1, then RUN with all enables 1; `stall_cycles`=4.
- Redirect with pending miss: `exmem_redirect`=1 and `dstall` for 2 cycles → no flush for 2 cycles; on the `dhit` cycle `ifid_flush`, `idex_flush`, `exmem_flush` = 1 and `flush_count`=1.
- Halt: `exmem_halt`=1 → flushes asserted, then DRAIN (`memwb_en`=1 only), then `halted`=1 with all enables 0 for 10 further cycles; `RST` → RUN, `halted`=0.
- Watchdog: `DWAIT_MAX`=3, `dhit` held low for 5 cycles → `mem_timeout`=1 from the 4th DWAIT edge, still 1 after `dhit` returns, cleared only by `RST`.
- Reset mid-stall: `RST` pulsed in DWAIT → during reset all enables 0 and all flushes 1; afterwards state RUN, counters 0.
